// File: rtl/tfs_huffman_stream_decoder.sv
// Streaming Huffman decoder for TFS compressed blocks (0->'0', +1->'10', -1->'11', bit 0 first).
// Optional macro TFS_DEC_STATS_EN adds per-symbol trit counters stat_neg/stat_zero/stat_pos.
module tfs_huffman_stream_decoder #(
    parameter int TRITS    = 32,
    parameter int MAX_BITS = 64,
    parameter int BC_W     = 7,
    parameter int TC_W     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] in_bits,
    input  logic [BC_W-1:0]     in_bit_count,
    input  logic [1:0]          in_guardian,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_trit,
    output logic                out_last,
    output logic                done,
    output logic [2:0]          err,
`ifdef TFS_DEC_STATS_EN
    output logic [TC_W-1:0]     stat_neg,
    output logic [TC_W-1:0]     stat_zero,
    output logic [TC_W-1:0]     stat_pos,
`endif
    output logic [TC_W-1:0]     trit_count,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_LEN   = 3'd1;
    localparam logic [2:0] E_TRUNC = 3'd2;
    localparam logic [2:0] E_SHORT = 3'd3;
    localparam logic [2:0] E_LONG  = 3'd4;
    localparam logic [2:0] E_GUARD = 3'd5;

    localparam int IW = $clog2(MAX_BITS);

    logic [1:0]          state;
    logic [MAX_BITS-1:0] bits_q;
    logic [BC_W-1:0]     count_q;
    logic [1:0]          guard_q;
    logic [BC_W-1:0]     pos;
    logic [1:0]          acc;

    logic                slot_free;
    logic [BC_W:0]       pos_x;
    logic [BC_W:0]       pos1_x;
    logic [BC_W:0]       count_x;
    logic                bit0;
    logic                bit1;
    logic                at_end;
    logic                pos_past;
    logic                pair_cut;
    logic [1:0]          trit_nxt;
    logic [1:0]          adv;
    logic [2:0]          acc_sum;
    logic [1:0]          acc_nxt;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        slot_free = !out_valid || out_ready;
        pos_x     = {1'b0, pos};
        pos1_x    = pos_x + {{BC_W{1'b0}}, 1'b1};
        count_x   = {1'b0, count_q};
        bit0      = bits_q[pos[IW-1:0]];
        bit1      = bits_q[pos1_x[IW-1:0]];
        at_end    = (trit_count == TC_W'(TRITS));
        pos_past  = (pos_x >= count_x);
        pair_cut  = (pos1_x >= count_x);
        trit_nxt  = 2'b00;
        adv       = 2'd1;
        if (bit0) begin
            trit_nxt = bit1 ? 2'b10 : 2'b01;
            adv      = 2'd2;
        end
        // Trit encoding doubles as its residue, so acc is a plain mod-3 sum.
        acc_sum = {1'b0, acc} + {1'b0, trit_nxt};
        acc_nxt = (acc_sum >= 3'd3) ? 2'(acc_sum - 3'd3) : acc_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bits_q     <= '0;
            count_q    <= '0;
            guard_q    <= '0;
            pos        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_trit   <= 2'b00;
            out_last   <= 1'b0;
            done       <= 1'b0;
            err        <= E_OK;
            trit_count <= '0;
`ifdef TFS_DEC_STATS_EN
            stat_neg   <= '0;
            stat_zero  <= '0;
            stat_pos   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bits_q     <= in_bits;
                        count_q    <= in_bit_count;
                        guard_q    <= in_guardian;
                        pos        <= '0;
                        acc        <= '0;
                        trit_count <= '0;
                        out_last   <= 1'b0;
`ifdef TFS_DEC_STATS_EN
                        stat_neg   <= '0;
                        stat_zero  <= '0;
                        stat_pos   <= '0;
`endif
                        if (in_bit_count > BC_W'(MAX_BITS)) begin
                            err   <= E_LEN;
                            state <= ST_CHECK;
                        end else begin
                            err   <= E_OK;
                            state <= ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (slot_free) begin
                        if (at_end) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_CHECK;
                        end else if (pos_past) begin
                            err       <= E_SHORT;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_CHECK;
                        end else if (bit0 && pair_cut) begin
                            err       <= E_TRUNC;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= ST_CHECK;
                        end else begin
                            out_valid  <= 1'b1;
                            out_trit   <= trit_nxt;
                            out_last   <= (trit_count == TC_W'(TRITS - 1));
                            trit_count <= trit_count + 1'b1;
                            acc        <= acc_nxt;
                            pos        <= pos + {{(BC_W-2){1'b0}}, adv};
`ifdef TFS_DEC_STATS_EN
                            case (trit_nxt)
                                2'b10:   stat_neg  <= stat_neg + 1'b1;
                                2'b01:   stat_pos  <= stat_pos + 1'b1;
                                default: stat_zero <= stat_zero + 1'b1;
                            endcase
`endif
                        end
                    end
                end
                ST_CHECK: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (err == E_OK) begin
                        if (pos != count_q)
                            err <= E_LONG;
                        else if (acc != guard_q)
                            err <= E_GUARD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tfs_huffman_stream_decoder.md
Name: tfs_huffman_stream_decoder

Overview:
Streaming TFS Huffman decoder for the read path of the STT-MRAM file system. Takes one compressed block (up to 64 bits, fixed code 0→'0', +1→'10', −1→'11', bit 0 first) through a valid/ready load port. Emits the trits one per cycle on a valid/ready output stream, then verifies length and the block's guardian trit. Sits between the TFS block reader and trit consumers, and decodes what tfs_huffman_encoder produces.

Parameters:
TRITS, 32, trits per block
MAX_BITS, 64, compressed word width
BC_W, 7, bit-count width (holds 0..MAX_BITS)
TC_W, 6, trit-count width (holds 0..TRITS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  compressed block offered
in_ready  out  1  decoder can accept a block
in_bits  in  MAX_BITS  compressed word, bit 0 = first code bit
in_bit_count  in  BC_W  valid bits in in_bits
in_guardian  in  2  expected guardian (0,1,2)
out_valid  out  1  out_trit valid
out_ready  in  1  consumer accepts trit
out_trit  out  2  00=0, 01=+1, 10=−1
out_last  out  1  marks trit number TRITS of the block
done  out  1  one-cycle pulse, block finished
err  out  3  result code, valid while done=1
trit_count  out  TC_W  trits emitted for the current or last block
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_trit=0, out_last=0, done=0, err=0, trit_count=0, busy=0. Internal pos/acc are cleared.
- Reset mid-block: the partial block is discarded, no done pulse, and out_valid drops on the reset edge.
- States: IDLE, DECODE, CHECK.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch bits, count and guardian. Clear pos, trit_count and acc (guardian accumulator).
  - If in_bit_count>MAX_BITS, latch err=1 (LEN) and go to CHECK. Otherwise go to DECODE.
- DECODE: in_ready=0. The output slot is free when out_valid=0 or out_ready=1.
  - When the slot is free and trit_count<TRITS:
    - If pos>=count: err=3 (SHORT), out_valid<=0, go to CHECK.
    - If bit[pos]=0: emit 00, pos+=1.
    - If bit[pos]=1 and pos+1>=count: err=2 (TRUNC), out_valid<=0, go to CHECK.
    - Else emit 01 if bit[pos+1]=0, or 10 if bit[pos+1]=1; pos+=2.
    - Each emit sets out_valid<=1, trit_count+=1, acc=(acc+trit) mod 3, and out_last<=(new trit_count==TRITS).
  - When the slot is free and trit_count==TRITS: out_valid<=0, go to CHECK.
  - Throughput is 1 trit per cycle with out_ready held high. The first out_valid appears on the first edge after the accept edge.
  - out_trit, out_valid and out_last hold stable while out_valid&!out_ready.
- CHECK (one cycle): done<=1 and err is finalised.
  - If no error is latched: err=4 (LONG) if pos!=count, else 5 (GUARD) if acc!=guardian, else 0.
  - Next state is IDLE. done deasserts the following cycle; err and trit_count hold until the next accept.
- Error priority: LEN > TRUNC > SHORT > LONG > GUARD. The guardian is not checked on LEN, TRUNC or SHORT.
- Arithmetic: acc uses the 2-bit trit encoding as the value (0, 1, 2), added mod 3. No trit value 11 is ever emitted.
- A new block can be accepted the cycle after done.

Optional Feature:
TFS_DEC_STATS_EN
- Defined: adds outputs stat_neg, stat_zero and stat_pos (each TC_W bits).
  - They count emitted 10, 00 and 01 trits, clear on accept, and are frozen from done until the next accept.
  - stat_neg+stat_zero+stat_pos==trit_count at done.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- All-zero block: in_bits=0, count=32, guardian=0, out_ready=1 → 32 consecutive trits 00, out_last on the 32nd, then done with err=0 and trit_count=32.
- All-ones blocks:
  - bits=64'h5555_5555_5555_5555, count=64, guardian=2 → 32×01, err=0.
  - bits=64'hFFFF_FFFF_FFFF_FFFF, count=64, guardian=1 → 32×10, err=0.
- Backpressure: mixed block bits=64'h...D, out_ready toggling 1,0,1,0 → trit sequence identical to the out_ready=1 run, with no drops or duplicates. out_trit holds while stalled.
- Guardian and long:
  - All-zero block with guardian=1 → 32 trits, err=5.
  - bits=0, count=40 → 32 trits, err=4.
- Malformed input:
  - bits=1, count=1 → 0 trits, err=2.
  - bits=0, count=10 → 10 trits, no out_last, err=3.
  - count=65 → 0 trits, err=1, done one cycle after the accept.
- Reset after 5 trits emitted → out_valid=0, in_ready=1, trit_count=0, and no done pulse. The next block decodes correctly.
